// File: rtl/scp_079_pkg.sv
// Shared state encoding and timer thresholds for the scp_079 containment controller.
package scp_079_pkg;

  typedef enum logic [2:0] {
    ST_MONITOR  = 3'd0,
    ST_WARN     = 3'd1,
    ST_PHASE2   = 3'd2,
    ST_PHASE3   = 3'd3,
    ST_LOCKDOWN = 3'd4,
    ST_BREACH   = 3'd5
  } state_e;

  localparam logic [5:0] T_MON     = 6'd35;
  localparam logic [5:0] T_PH2     = 6'd20;
  localparam logic [5:0] T_PH3     = 6'd5;
  localparam logic [5:0] T_PH3_TRB = 6'd9;
  localparam logic [5:0] T_BRCH    = 6'd4;

endpackage

// File: rtl/scp_079.sv
// scp_079 containment FSM: light/timer driven state sequencing with alarm decodes.
// Optional override feature enabled by defining SCP079_CHEAT_EN.
module scp_079
  import scp_079_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       green,
  input  logic       yellow,
  input  logic       red,
  input  logic [5:0] timer,
  output logic [2:0] state,
  output logic       a1,
  output logic       a2,
  output logic       a3,
  output logic       cheat_out
);

  state_e state_q, state_d;
  logic   flag_q, flag_d;
  logic   a1_q, a3_q;
  logic   cheat_q;
  logic   cheat_hit_s;

`ifdef SCP079_CHEAT_EN
  assign cheat_hit_s = green & yellow & red;
`else
  assign cheat_hit_s = 1'b0;
`endif

  // Next-state and trouble-flag logic: override > red > per-state rule.
  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    if (cheat_hit_s) begin
      state_d = ST_MONITOR;
      flag_d  = 1'b0;
    end else if (red && (state_q != ST_BREACH)) begin
      state_d = ST_LOCKDOWN;
    end else begin
      case (state_q)
        ST_MONITOR: begin
          if ((timer >= T_MON) && green) begin
            state_d = ST_PHASE2;
          end else if ((timer >= T_MON) && yellow) begin
            state_d = ST_WARN;
            flag_d  = 1'b1;
          end else begin
            state_d = ST_MONITOR;
          end
        end
        ST_WARN: begin
          if (green) state_d = ST_PHASE2;
          else       state_d = ST_WARN;
        end
        ST_PHASE2: begin
          if (timer >= T_PH2) state_d = ST_PHASE3;
          else                state_d = ST_PHASE2;
        end
        ST_PHASE3: begin
          // With trouble latched the phase runs longer and ends in breach.
          if (flag_q) begin
            if (timer >= T_PH3_TRB) state_d = ST_BREACH;
            else                    state_d = ST_PHASE3;
          end else begin
            if (timer >= T_PH3) state_d = ST_MONITOR;
            else                state_d = ST_PHASE3;
          end
        end
        ST_LOCKDOWN: begin
          if (!red && green) state_d = ST_MONITOR;
          else               state_d = ST_LOCKDOWN;
        end
        ST_BREACH: begin
          if (timer >= T_BRCH) begin
            state_d = ST_MONITOR;
            flag_d  = 1'b0;
          end else begin
            state_d = ST_BREACH;
          end
        end
        default: begin
          state_d = ST_MONITOR;
        end
      endcase
    end
  end

  // State, flag and alarm registers; alarms are decoded from the next state so
  // they track the registered state in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_MONITOR;
      flag_q  <= 1'b0;
      a1_q    <= 1'b0;
      a3_q    <= 1'b0;
      cheat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      a1_q    <= (state_d == ST_WARN);
      a3_q    <= (state_d == ST_LOCKDOWN) || (state_d == ST_BREACH);
      cheat_q <= cheat_hit_s;
    end
  end

  assign state     = state_q;
  assign a1        = a1_q;
  assign a2        = flag_q;
  assign a3        = a3_q;
  assign cheat_out = cheat_q;

endmodule

// File: tb/tb_scp_079.sv
// Scoreboard bench for scp_079: driver queues expected outputs, monitor compares.
module tb_scp_079;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       green = 1'b0, yellow = 1'b0, red = 1'b0;
  logic [5:0] timer = 6'd0;
  logic [2:0] state;
  logic       a1, a2, a3, cheat_out;

  typedef struct packed {
    logic [2:0] st;
    logic       a1;
    logic       a2;
    logic       a3;
    logic       ch;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  event chk_ev;

  scp_079 dut (
    .clock(clock), .reset_n(reset_n), .green(green), .yellow(yellow), .red(red),
    .timer(timer), .state(state), .a1(a1), .a2(a2), .a3(a3), .cheat_out(cheat_out)
  );

  always #5 clock = ~clock;

  // Monitor: outputs are sampled at the falling edge, or on demand after an async reset.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock or chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({state, a1, a2, a3, cheat_out} !== {e.st, e.a1, e.a2, e.a3, e.ch}) begin
          n_err++;
          $display("FAIL outputs #%0d: got state=%0d a1=%b a2=%b a3=%b cheat=%b, want state=%0d a1=%b a2=%b a3=%b cheat=%b",
                   n_cmp, state, a1, a2, a3, cheat_out, e.st, e.a1, e.a2, e.a3, e.ch);
        end
      end
    end
  end

  task automatic step(input logic g, input logic y, input logic r, input logic [5:0] t,
                      input logic [2:0] es, input logic ea1, input logic ea2,
                      input logic ea3, input logic ech);
    @(negedge clock);
    green = g; yellow = y; red = r; timer = t;
    @(posedge clock);
    exp_q.push_back('{st: es, a1: ea1, a2: ea2, a3: ea3, ch: ech});
  endtask

  // Reset pulse placed between edges; outputs must clear without any clock edge.
  task automatic do_reset();
    @(negedge clock);
    green = 1'b0; yellow = 1'b0; red = 1'b0; timer = 6'd0;
    #1 reset_n = 1'b0;
    #1 exp_q.push_back('{st: 3'd0, a1: 1'b0, a2: 1'b0, a3: 1'b0, ch: 1'b0});
    ->chk_ev;
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_flag;
    // Normal path: MONITOR -> PHASE2 -> PHASE3 -> MONITOR.
    do_reset();
    for (int t = 1; t <= 35; t++)
      step(1, 0, 0, 6'(t), (t >= 35) ? 3'd2 : 3'd0, 0, 0, 0, 0);
    for (int t = 1; t <= 20; t++)
      step(1, 0, 0, 6'(t), (t >= 20) ? 3'd3 : 3'd2, 0, 0, 0, 0);
    for (int t = 1; t <= 5; t++)
      step(1, 0, 0, 6'(t), (t >= 5) ? 3'd0 : 3'd3, 0, 0, 0, 0);

    // Red in PHASE2 locks down; green with red low releases.
    step(1, 0, 0, 6'd35, 3'd2, 0, 0, 0, 0);
    step(0, 0, 1, 6'd0,  3'd4, 0, 0, 1, 0);
    step(0, 0, 1, 6'd63, 3'd4, 0, 0, 1, 0);
    step(1, 0, 0, 6'd0,  3'd0, 0, 0, 0, 0);

    // Trouble path: WARN -> PHASE2 -> PHASE3 (long) -> BREACH -> MONITOR.
    do_reset();
    for (int t = 1; t <= 35; t++)
      step(0, 1, 0, 6'(t), (t >= 35) ? 3'd1 : 3'd0, t >= 35, t >= 35, 0, 0);
    step(0, 1, 0, 6'd40, 3'd1, 1, 1, 0, 0);
    step(1, 0, 0, 6'd0,  3'd2, 0, 1, 0, 0);
    for (int t = 1; t <= 20; t++)
      step(1, 0, 0, 6'(t), (t >= 20) ? 3'd3 : 3'd2, 0, 1, 0, 0);
    for (int t = 1; t <= 9; t++)
      step(0, 0, 0, 6'(t), (t >= 9) ? 3'd5 : 3'd3, 0, 1, t >= 9, 0);
    // Red is ignored in BREACH.
    step(0, 0, 1, 6'd0, 3'd5, 0, 1, 1, 0);
    step(0, 0, 1, 6'd3, 3'd5, 0, 1, 1, 0);
    for (int t = 1; t <= 4; t++)
      step(0, 0, 0, 6'(t), (t >= 4) ? 3'd0 : 3'd5, 0, t < 4, t < 4, 0);

    // Green beats yellow at threshold in MONITOR.
    step(1, 1, 0, 6'd35, 3'd2, 0, 0, 0, 0);
    do_reset();

    // All three lights in PHASE3 with trouble latched.
    step(0, 1, 0, 6'd35, 3'd1, 1, 1, 0, 0);
    step(1, 0, 0, 6'd0,  3'd2, 0, 1, 0, 0);
    step(1, 0, 0, 6'd20, 3'd3, 0, 1, 0, 0);
`ifdef SCP079_CHEAT_EN
    step(1, 1, 1, 6'd0, 3'd0, 0, 0, 0, 1);
    step(0, 0, 0, 6'd0, 3'd0, 0, 0, 0, 0);
    exp_flag = 1'b0;
`else
    step(1, 1, 1, 6'd0, 3'd4, 0, 1, 1, 0);
    step(1, 0, 0, 6'd0, 3'd0, 0, 1, 0, 0);
    exp_flag = 1'b1;
`endif
    // Back into PHASE3, then an async reset pulse between edges.
    step(1, 0, 0, 6'd35, 3'd2, 0, exp_flag, 0, 0);
    step(1, 0, 0, 6'd20, 3'd3, 0, exp_flag, 0, 0);
    do_reset();
    step(1, 0, 0, 6'd10, 3'd0, 0, 0, 0, 0);
    step(0, 0, 0, 6'd63, 3'd0, 0, 0, 0, 0);

    @(negedge clock);
    @(negedge clock);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scp_079.md
SCP_079 -- requirements
Module: scp_079

Interface
REQ-001 clock  input  1  system clock; all state changes on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 green  input  1  light status "normal"; sampled each rising edge.
REQ-004 yellow  input  1  light status "warning"; sampled each rising edge.
REQ-005 red  input  1  light status "danger"; sampled each rising edge.
REQ-006 timer  input  6  externally driven elapsed-time count, unsigned; DUT only compares it and never counts.
REQ-007 state  output  3  current FSM state code.
REQ-008 a1  output  1  warning alarm.
REQ-009 a2  output  1  trouble flag.
REQ-010 a3  output  1  lockdown/breach alarm.
REQ-011 cheat_out  output  1  one-cycle override pulse; constant 0 when the feature is compiled out.

Function
REQ-012 States: 0 MONITOR, 1 WARN, 2 PHASE2, 3 PHASE3, 4 LOCKDOWN, 5 BREACH; codes 6/7 go to MONITOR on the next edge.
REQ-013 Thresholds: T_MON=35, T_PH2=20, T_PH3=5, T_PH3_TRB=9, T_BRCH=4; all compare timer >= threshold, unsigned, 6-bit.
REQ-014 Priority each edge: cheat (if enabled) > red > per-state rule.
REQ-015 red=1 in any state except BREACH -> LOCKDOWN next edge.
REQ-016 MONITOR: timer>=T_MON with green=1 -> PHASE2; with yellow=1 (green=0) -> WARN and set trouble flag; otherwise hold.
REQ-017 WARN: green=1 -> PHASE2; else hold.
REQ-018 PHASE2: timer>=T_PH2 -> PHASE3; else hold.
REQ-019 PHASE3, flag=0: timer>=T_PH3 -> MONITOR.
REQ-020 PHASE3, flag=1: timer>=T_PH3_TRB -> BREACH; T_PH3..T_PH3_TRB-1 hold.
REQ-021 BREACH: timer>=T_BRCH -> MONITOR and clear flag; red is ignored in BREACH.
REQ-022 LOCKDOWN: red=0 and green=1 -> MONITOR; flag unchanged.
REQ-023 Outputs are Moore decodes of the registered state/flag, valid the same cycle: a1 = (state==WARN); a2 = flag; a3 = (state==LOCKDOWN or BREACH).
REQ-024 Simultaneous green and yellow in MONITOR at threshold: green wins.

Reset
REQ-025 reset_n=0 asynchronously forces state=0, flag=0, a1=a2=a3=0, cheat_out=0.
REQ-026 Deassertion mid-operation resumes from MONITOR on the first rising edge with reset_n=1.

Configuration
REQ-027 Macro SCP079_CHEAT_EN defined: green=yellow=red=1 on an edge forces MONITOR, clears the flag and drives cheat_out=1 for exactly that following cycle (registered).
REQ-028 Macro SCP079_CHEAT_EN undefined: cheat_out tied 0; all-three-high input is handled as red.

Structure
REQ-029 Package scp_079_pkg holds the state enumeration and the five threshold constants.
REQ-030 Single module; no sub-module is required.

Verification
REQ-031 Reset, green=1, timer ramps 1..35 -> state 0 until timer=35, then 2; timer 1..20 -> 3; timer 1..5 -> 0; a1=a2=a3=0 throughout.
REQ-032 Reset, yellow=1, timer ramps to 35 -> state 1, a1=1, a2=1; green=1 -> 2; timer 1..20 -> 3; timer 1..9 -> holds at 5..8, goes to 5 at 9, a3=1; timer 1..4 -> 0, a2=0.
REQ-033 red=1 while in state 2 -> state 4, a3=1; red=0, green=1 -> state 0.
REQ-034 red=1 while in state 5 -> state remains 5.
REQ-035 SCP079_CHEAT_EN defined, all three lights high in state 3 -> state 0, cheat_out=1 one cycle, a2=0; undefined -> state 4, cheat_out=0.
REQ-036 reset_n pulsed low between edges in state 3 -> state=0 and outputs 0 immediately, without a clock edge.
